// File: rtl/regfile_pkg.sv
// Shared defaults and write-port indices for the multi-port MIPS register file.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int WP_ALU     = 0;
  localparam int WP_LOAD    = 1;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, issue wins on the same edge.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [1:0]               wr_act,
  input  logic [1:0][ADDR_W-1:0]   wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_RD-1:0]        rd_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy;
  logic             iss_ok;

  assign iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == '0);

  // Set is applied after the clears so a new producer supersedes a completing one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_act[p]) busy[wr_addr[p]] <= 1'b0;
      if (iss_ok) busy[iss_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    assign a   = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = (wr_act[WP_ALU] && wr_addr[WP_ALU] == a) ||
                 (wr_act[WP_LOAD] && wr_addr[WP_LOAD] == a);
    assign rd_busy[k] = busy[a] & ~hit;
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD bypassed read ports, ALU and load write ports, busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     wr_conflict
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [1:0][ADDR_W-1:0]       wa;
  logic [1:0][DATA_W-1:0]       wd;
  logic [1:0]                   wr_act;

  assign wa = wr_addr;
  assign wd = wr_data;

  // A write to r0 is dropped entirely when r0 is hardwired.
  for (genvar p = 0; p < 2; p++) begin : g_wp
    assign wr_act[p] = wr_en[p] && !(ZERO_REG != 0 && wa[p] == '0);
  end

  // Load port is written last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      if (wr_act[WP_ALU])  mem[wa[WP_ALU]]  <= wd[WP_ALU];
      if (wr_act[WP_LOAD]) mem[wa[WP_LOAD]] <= wd[WP_LOAD];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_conflict <= 1'b0;
    else        wr_conflict <= wr_en[WP_ALU] && wr_en[WP_LOAD] &&
                               (wa[WP_ALU] == wa[WP_LOAD]) && (wa[WP_ALU] != '0);
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      d = mem[a];
      if (wr_act[WP_ALU] && wa[WP_ALU] == a)   d = wd[WP_ALU];
      if (wr_act[WP_LOAD] && wa[WP_LOAD] == a) d = wd[WP_LOAD];
      if (ZERO_REG != 0 && a == '0)            d = '0;
    end
    assign rd_data[k*DATA_W +: DATA_W] = d;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .wr_act  (wr_act),
    .wr_addr (wa),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .rd_busy (rd_busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with r0 hardwired, one with r0 ordinary.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [63:0] rd_data, rd_data0;
  logic [1:0]  rd_busy, rd_busy0;
  logic        wr_conflict, wr_conflict0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  regfile_mp #(.ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .wr_conflict(wr_conflict)
  );

  regfile_mp #(.ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .wr_conflict(wr_conflict0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    iss_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    #1;
    chk("reset_rd0", rd_data[31:0], 32'h0);
    chk("reset_busy", {30'd0, rd_busy}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // r5 = DEADBEEF and busy, then async reset mid-cycle
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    iss_en = 1'b1; iss_addr = 5'd5;
    @(negedge clk);
    idle(); rd_addr = {5'd5, 5'd5};
    #1;
    chk("pre_reset_rd0", rd_data[31:0], 32'hDEADBEEF);
    chk("pre_reset_busy", {30'd0, rd_busy}, 32'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_rd0", rd_data[31:0], 32'h0);
    chk("async_reset_rd1", rd_data[63:32], 32'h0);
    chk("async_reset_busy", {30'd0, rd_busy}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // write r5 with same-cycle read on both ports
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h12345678};
    rd_addr = {5'd5, 5'd5};
    #1;
    chk("bypass_r5_p0", rd_data[31:0], 32'h12345678);
    chk("bypass_r5_p1", rd_data[63:32], 32'h12345678);
    @(negedge clk) idle();
    #1;
    chk("array_r5_p0", rd_data[31:0], 32'h12345678);
    chk("array_r5_p1", rd_data[63:32], 32'h12345678);

    // r0 write: hardwired vs ordinary
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
    rd_addr = {5'd5, 5'd0};
    #1;
    chk("r0_zero_bypass", rd_data[31:0], 32'h0);
    chk("r0_plain_bypass", rd_data0[31:0], 32'hFFFFFFFF);
    @(negedge clk) idle();
    #1;
    chk("r0_zero_array", rd_data[31:0], 32'h0);
    chk("r0_plain_array", rd_data0[31:0], 32'hFFFFFFFF);
    chk("r0_no_conflict", {31'd0, wr_conflict}, 32'h0);

    // dual write collision on r7
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2, 32'h1};
    rd_addr = {5'd0, 5'd7};
    #1;
    chk("collide_bypass", rd_data[31:0], 32'h2);
    chk("conflict_before", {31'd0, wr_conflict}, 32'h0);
    @(posedge clk) #1;
    idle();
    chk("conflict_pulse", {31'd0, wr_conflict}, 32'h1);
    chk("collide_array", rd_data[31:0], 32'h2);
    @(posedge clk) #1;
    chk("conflict_end", {31'd0, wr_conflict}, 32'h0);

    // issue r9, then write it
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd9; rd_addr = {5'd0, 5'd9};
    #1;
    chk("issue_not_bypassed", {31'd0, rd_busy[0]}, 32'h0);
    @(negedge clk) idle();
    #1;
    chk("issue_busy", {31'd0, rd_busy[0]}, 32'h1);
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hA5};
    #1;
    chk("wb_busy_bypass", {31'd0, rd_busy[0]}, 32'h0);
    chk("wb_data_bypass", rd_data[31:0], 32'hA5);
    @(negedge clk) idle();
    #1;
    chk("wb_busy_cleared", {31'd0, rd_busy[0]}, 32'h0);
    chk("wb_data_array", rd_data[31:0], 32'hA5);

    // issue and load write on r3 at the same edge: set wins
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd3;
    wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h33, 32'h0};
    rd_addr = {5'd0, 5'd3};
    #1;
    chk("same_edge_bypass", {31'd0, rd_busy[0]}, 32'h0);
    @(negedge clk) idle();
    #1;
    chk("same_edge_set_wins", {31'd0, rd_busy[0]}, 32'h1);
    chk("same_edge_data", rd_data[31:0], 32'h33);
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h44};
    @(negedge clk) idle();
    #1;
    chk("later_write_clears", {31'd0, rd_busy[0]}, 32'h0);
    chk("later_write_data", rd_data[31:0], 32'h44);

    // issue to r0: ignored only when hardwired
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    @(negedge clk) idle();
    #1;
    chk("r0_zero_never_busy", {31'd0, rd_busy[0]}, 32'h0);
    chk("r0_plain_busy", {31'd0, rd_busy0[0]}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS datapath, successor to the single-write, two-read register file. It provides NUM_RD combinational read ports with same-cycle write-to-read bypass, two write ports (ALU writeback and load writeback), a hardwired zero register, and a per-register busy scoreboard. The decode stage uses the scoreboard to stall on pending producers. It sits between decode (read/issue) and writeback (write).

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: when 1, register 0 reads as 0, ignores writes and is never busy.

- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W: read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W: read data, combinational, bypassed.
- rd_busy  out  NUM_RD: scoreboard bit for each read address, combinational, bypassed.
- wr_en  in  2: write enables; port 0 is ALU writeback, port 1 is load writeback.
- wr_addr  in  2*ADDR_W: write addresses.
- wr_data  in  2*DATA_W: write data.
- iss_en  in  1: an instruction issues with a destination register.
- iss_addr  in  ADDR_W: destination register to mark busy.
- wr_conflict  out  1: registered pulse; both write ports targeted the same non-zero address in the previous cycle.

## Operation
- Reset (rst_n=0, async): all registers cleared to 0, all busy bits cleared, wr_conflict=0. rd_data therefore reads 0 and rd_busy reads 0 during and after reset.
- Write: at posedge clk, for each p with wr_en[p]=1 and a non-zero address, reg[wr_addr[p]] <= wr_data[p]. When ZERO_REG=0, address 0 is an ordinary register.
- Dual-write collision (same address, both enabled): port 1 (load) wins. wr_conflict=1 on the next cycle for exactly one cycle.
- Read, per port k, in priority order:
  1. ZERO_REG and address 0: data 0.
  2. Address matches an enabled write port: that port's wr_data, port 1 over port 0.
  3. Otherwise: array contents.
- Scoreboard: at posedge clk, a write on any port clears busy[wr_addr]; iss_en sets busy[iss_addr].
  - Same edge, same address, issue and write: set wins, because a new producer supersedes the completed one.
  - Issue to register 0 with ZERO_REG=1: ignored.
- rd_busy[k] = busy[rd_addr[k]] & ~(any enabled write to rd_addr[k] this cycle). The write being bypassed resolves the hazard in the same cycle.
- Issue is not bypassed into rd_busy: a same-cycle issue becomes visible next cycle.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, wr_*).
- Write latency: data visible via bypass in the same cycle, and from the array from the cycle after the edge.
- Scoreboard update: 1 cycle.
- wr_conflict: 1 cycle after the colliding write, width 1 cycle.
- Reset asserted mid-cycle clears state immediately; writes coincident with reset release are lost.

## Structure
- Shared package regfile_pkg holds:
  - default DATA_W, ADDR_W, NUM_RD;
  - the write-port index constants WP_ALU=0 and WP_LOAD=1.
- Sub-module regfile_scoreboard contains the busy vector, its set/clear/priority logic and the rd_busy bypass.
- The top level holds the array, the write/bypass muxes and wr_conflict.

## Test plan
- Reset with registers previously written (0xDEADBEEF in r5): assert rst_n=0 asynchronously -> rd_data=0 and rd_busy=0 on all ports without a clock edge.
- Write r5=0x12345678 on port 0 while reading r5 on ports 0 and 1 in the same cycle -> both read 0x12345678 that cycle and on following cycles.
- Write r0=0xFFFFFFFF (ZERO_REG=1) -> r0 reads 0. Repeat with ZERO_REG=0 -> reads 0xFFFFFFFF.
- Both ports write r7 (port 0: 0x1, port 1: 0x2) -> r7 reads 0x2 that cycle (bypass) and after the edge; wr_conflict=1 for exactly one cycle.
- Issue r9 -> rd_busy for r9 becomes 1 next cycle. Then write r9=0xA5 -> rd_busy=0 and rd_data=0xA5 in the write cycle, busy cleared after the edge.
- Issue r3 and write r3 on the same edge -> busy[r3] remains 1. A subsequent write to r3 clears it.
